// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point datapath blocks.
// Contents:
//   WIDTH         - mantissa operand width used by the divider
//   CNT_W         - iteration counter width, clog2(WIDTH)
//   state_e       - divider FSM state encoding (idle, run, finish)
//   DBZ_QUOTIENT  - quotient reported when dividing by zero (all ones)
package fp_pkg;

  localparam int unsigned WIDTH = 18;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFin  = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/subtractor19.sv
// (WIDTH+1)-bit unsigned subtractor with borrow-out, the subtracting
// counterpart of the datapath adder.
// Ports:
//   a      - minuend
//   b      - subtrahend
//   diff   - a - b, modulo 2^(WIDTH+1)
//   borrow - high when b > a
module subtractor19
  import fp_pkg::*;
(
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  output logic [WIDTH:0] diff,
  output logic           borrow
);

  logic [WIDTH+1:0] full;

  // One extra bit captures the borrow out of the top position.
  always_comb begin
    full   = {1'b0, a} - {1'b0, b};
    diff   = full[WIDTH:0];
    borrow = full[WIDTH+1];
  end

endmodule

// File: rtl/div18_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// A division by a non-zero divisor takes WIDTH run cycles followed by a
// one-cycle done pulse; a zero divisor finishes immediately with dbz set.
// Ports:
//   clk, rst - clock and asynchronous active-high reset
//   start    - request, sampled only while busy is low
//   a, b     - dividend and divisor, captured on the accepting edge
//   q, r     - registered quotient and remainder, held between results
//   busy     - high while the iteration is running
//   done     - one-cycle pulse, q/r/dbz valid in that cycle
//   dbz      - divide-by-zero flag, held with q and r
module div18_seq
  import fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             dbz
);

  state_e state_q, state_d;

  logic [WIDTH-1:0] dvd_q;   // dividend, shifted out MSB-first
  logic [WIDTH-1:0] dvs_q;   // divisor
  logic [WIDTH:0]   pr_q;    // partial remainder, one bit wider than operands
  logic [WIDTH-1:0] quo_q;   // quotient bits, shifted in at the LSB
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] q_q, r_q;
  logic             dbz_q;

  logic [WIDTH:0]   pr_shift, trial, pr_next;
  logic [WIDTH-1:0] quo_next;
  logic             borrow, accept, last;

  always_comb begin
    pr_shift = {pr_q[WIDTH-1:0], dvd_q[WIDTH-1]};
  end

  subtractor19 u_sub (
    .a      (pr_shift),
    .b      ({1'b0, dvs_q}),
    .diff   (trial),
    .borrow (borrow)
  );

  // Restore on borrow: keep the shifted remainder and record a zero bit.
  always_comb begin
    pr_next  = borrow ? pr_shift : trial;
    quo_next = {quo_q[WIDTH-2:0], ~borrow};
    last     = (cnt_q == CNT_W'(WIDTH - 1));
    accept   = start && (state_q != StRun);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StFin: begin
        if (start) begin
          state_d = (b == '0) ? StFin : StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        if (last) state_d = StFin;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_q <= '0;
      dvs_q <= '0;
      pr_q  <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      q_q   <= '0;
      r_q   <= '0;
      dbz_q <= 1'b0;
    end else if (accept) begin
      dvd_q <= a;
      dvs_q <= b;
      pr_q  <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      if (b == '0) begin
        q_q   <= DBZ_QUOTIENT;
        r_q   <= a;
        dbz_q <= 1'b1;
      end
    end else if (state_q == StRun) begin
      dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
      pr_q  <= pr_next;
      quo_q <= quo_next;
      cnt_q <= cnt_q + CNT_W'(1);
      if (last) begin
        q_q   <= quo_next;
        r_q   <= pr_next[WIDTH-1:0];
        dbz_q <= 1'b0;
      end
    end
  end

  always_comb begin
    q    = q_q;
    r    = r_q;
    dbz  = dbz_q;
    busy = (state_q == StRun);
    done = (state_q == StFin);
  end

endmodule

// File: tb/tb_div18_seq.sv
// Self-checking bench for div18_seq: a timeline reference model tracks when
// each accepted request must show busy/done and what result it must hold,
// while directed cases pin the model with hand-computed quotients.
module tb_div18_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [17:0] a = '0;
  logic [17:0] b = '0;
  logic [17:0] q, r;
  logic        busy, done, dbz;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  div18_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .q     (q),
    .r     (r),
    .busy  (busy),
    .done  (done),
    .dbz   (dbz)
  );

  task automatic check(input string nm, input longint act, input longint want);
    n_checks++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, want, $time);
    end
  endtask

  // Reference model: edge counter plus the edge at which the current
  // request was accepted. Busy spans cycles 1..18 after acceptance, done
  // is cycle 19 (or cycle 1 for a zero divisor).
  int          ec = 0;
  int          m_e = 0;
  bit          m_act = 1'b0;
  bit          m_dbz = 1'b0;
  logic [17:0] pq = '0, prm = '0, hq = '0, hr = '0;
  bit          pd = 1'b0, hd = 1'b0;

  function automatic bit model_busy(input int e);
    return m_act && !m_dbz && (e >= m_e) && (e <= m_e + 17);
  endfunction

  function automatic bit model_done(input int e);
    return m_act && (e == m_e + (m_dbz ? 0 : 18));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act = 1'b0;
      hq = '0;
      hr = '0;
      hd = 1'b0;
    end else begin
      if (start && !model_busy(ec)) begin
        m_act = 1'b1;
        m_e   = ec + 1;
        m_dbz = (b == 0);
        pq    = (b == 0) ? 18'h3FFFF : 18'(int'(a) / int'(b));
        prm   = (b == 0) ? a : 18'(int'(a) % int'(b));
        pd    = (b == 0);
      end
      ec++;
      if (model_done(ec)) begin
        hq = pq;
        hr = prm;
        hd = pd;
      end
    end
  end

  // Compare process, sampled 2 time units after each rising edge.
  always @(posedge clk) begin
    #2;
    if (rst) begin
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_q", q, 0);
      check("rst_r", r, 0);
      check("rst_dbz", dbz, 0);
    end else begin
      check("busy", busy, model_busy(ec));
      check("done", done, model_done(ec));
      if (!model_busy(ec)) begin
        check("q", q, hq);
        check("r", r, hr);
        check("dbz", dbz, hd);
      end
    end
  end

  // Issue one request and wait for its done pulse; noise scrambles a/b
  // while busy and pulses a second start in cycle 4.
  task automatic run_div(input logic [17:0] ta, input logic [17:0] tb, input logic [17:0] eq,
                         input logic [17:0] er, input bit ed, input int elat, input bit noise);
    int n;
    @(negedge clk);
    a = ta;
    b = tb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 40) begin
      if (noise) begin
        a = 18'($urandom);
        b = 18'($urandom);
        start = 1'b0;
        if (n == 4) begin
          a = 18'd50;
          b = 18'd5;
          start = 1'b1;
        end
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("latency", n, elat);
    check("res_q", q, eq);
    check("res_r", r, er);
    check("res_dbz", dbz, ed);
  endtask

  initial begin
    logic [17:0] ta, tb;
    int n, ndone;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases with hand-computed results.
    run_div(18'd100, 18'd7, 18'd14, 18'd2, 1'b0, 19, 1'b0);
    run_div(18'd262143, 18'd1, 18'd262143, 18'd0, 1'b0, 19, 1'b0);
    run_div(18'd5, 18'd9, 18'd0, 18'd5, 1'b0, 19, 1'b0);
    run_div(18'd1234, 18'd0, 18'h3FFFF, 18'd1234, 1'b1, 1, 1'b0);
    run_div(18'd1000, 18'd3, 18'd333, 18'd1, 1'b0, 19, 1'b1);
    repeat (2) @(negedge clk);

    // Start held high: second request accepted in the done cycle.
    a = 18'd200;
    b = 18'd10;
    start = 1'b1;
    ndone = 0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          check("b2b_first_cycle", c, 19);
          check("b2b_q1", q, 20);
          check("b2b_r1", r, 0);
        end else begin
          check("b2b_second_cycle", c, 38);
          check("b2b_q2", q, 0);
          check("b2b_r2", r, 99);
        end
      end
      if (c == 19) begin
        a = 18'd99;
        b = 18'd100;
      end
      if (c == 20) start = 1'b0;
    end
    check("b2b_done_count", ndone, 2);

    // Reset in cycle 7 of a division.
    @(negedge clk);
    a = 18'd1000;
    b = 18'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < 7) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_q", q, 0);
    check("abort_r", r, 0);
    check("abort_dbz", dbz, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    run_div(18'd17, 18'd4, 18'd4, 18'd1, 1'b0, 19, 1'b0);

    // Randomized requests, including zero and tiny divisors.
    for (int i = 0; i < 40; i++) begin
      ta = 18'($urandom);
      case ($urandom_range(0, 3))
        0: tb = '0;
        1: tb = 18'($urandom_range(1, 15));
        2: tb = 18'($urandom_range(ta > 0 ? 1 : 1, 18'h3FFFF));
        default: tb = 18'($urandom);
      endcase
      if (tb == 0) begin
        run_div(ta, tb, 18'h3FFFF, ta, 1'b1, 1, 1'b0);
      end else begin
        run_div(ta, tb, 18'(int'(ta) / int'(tb)), 18'(int'(ta) % int'(tb)), 1'b0, 19,
                ($urandom_range(0, 1) == 1));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
